// File: rtl/red_pitaya_rst_clken_pkg.sv
// Shared types for the multi-channel reset / clock-enable sequencer.
// One state per channel: clock off, waking up, running, draining.
package red_pitaya_rst_clken_pkg;

  typedef enum logic [1:0] {OFF, WAKE, ON, DRAIN} rst_clken_st_t;

  localparam int CH_MAX = 16;

  // Wide enough for any legal channel count.
  typedef logic [CH_MAX-1:0] ch_mask_t;

endpackage

// File: rtl/red_pitaya_rst_clken_ch.sv
// Single-channel reset / clock-enable FSM with wake and drain counter.
// clk_en and reset_n are a registered decode of the current state.
module red_pitaya_rst_clken_ch
  import red_pitaya_rst_clken_pkg::*;
#(
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             want,
  input  logic             up_ok,
  input  logic             dn_ok,
  input  logic [CTR_W-1:0] dly_on,
  input  logic [CTR_W-1:0] dly_off,
  output logic             clk_en,
  output logic             reset_n,
  output rst_clken_st_t    state
);

  localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

  rst_clken_st_t    state_reg;
  logic [CTR_W-1:0] ctr_reg;

  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_reg <= OFF;
      ctr_reg   <= '0;
      clk_en    <= 1'b0;
      reset_n   <= 1'b0;
    end else begin
      // Both outputs decode the same state, so reset_n can never be high
      // while clk_en is low, on any path.
      clk_en  <= (state_reg != OFF);
      reset_n <= (state_reg == ON);

      case (state_reg)
        OFF: begin
          if (want && up_ok) begin
            state_reg <= WAKE;
            ctr_reg   <= dly_on;
          end
        end
        WAKE: begin
          if (!want) begin
            state_reg <= DRAIN;
            ctr_reg   <= dly_off;
          end else if (ctr_reg == '0) begin
            state_reg <= ON;
          end else begin
            ctr_reg <= ctr_reg - CTR_ONE;
          end
        end
        ON: begin
          if (!want && dn_ok) begin
            state_reg <= DRAIN;
            ctr_reg   <= dly_off;
          end
        end
        DRAIN: begin
          // Re-enable goes straight back to WAKE so clk_en never dips low.
          if (want) begin
            state_reg <= WAKE;
            ctr_reg   <= dly_on;
          end else if (ctr_reg == '0) begin
            state_reg <= OFF;
          end else begin
            ctr_reg <= ctr_reg - CTR_ONE;
          end
        end
        default: begin
          state_reg <= OFF;
          ctr_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/red_pitaya_rst_clken_seq.sv
// Multi-channel reset / clock-enable sequencer between the housekeeping
// registers and the gated DSP blocks; optional ordered power-up/down chain.
module red_pitaya_rst_clken_seq
  import red_pitaya_rst_clken_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CTR_W    = 4,
  parameter int SEQ_MODE = 0
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic [CH-1:0]    enable_i,
  input  logic [CTR_W-1:0] dly_on_i,
  input  logic [CTR_W-1:0] dly_off_i,
  output logic [CH-1:0]    clk_en_o,
  output logic [CH-1:0]    reset_n_o,
  output logic [CH-1:0]    ready_o,
  output logic             busy_o
);

  logic [CH-1:0] want;
  logic [CH-1:0] up_ok;
  logic [CH-1:0] dn_ok;
  logic          want_acc;
  rst_clken_st_t st [CH];

  // In chain mode a channel only wants power while every lower channel does.
  always_comb begin
    want     = '0;
    want_acc = 1'b1;
    for (int k = 0; k < CH; k++) begin
      want_acc = (SEQ_MODE != 0) ? (want_acc & enable_i[k]) : enable_i[k];
      want[k]  = want_acc;
    end
  end

  // Clock running with reset held low means the channel is waking or draining.
  assign ready_o = clk_en_o & reset_n_o;
  assign busy_o  = |(clk_en_o & ~reset_n_o);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      if (gi == 0) begin : g_up_head
        assign up_ok[gi] = 1'b1;
      end else begin : g_up_link
        assign up_ok[gi] = (SEQ_MODE == 0) || ready_o[gi-1];
      end

      if (gi == CH - 1) begin : g_dn_tail
        assign dn_ok[gi] = 1'b1;
      end else begin : g_dn_link
        assign dn_ok[gi] = (SEQ_MODE == 0) || (st[gi+1] == OFF);
      end

      red_pitaya_rst_clken_ch #(
        .CTR_W (CTR_W)
      ) u_ch (
        .clk        (clk),
        .global_rst (global_rst),
        .want       (want[gi]),
        .up_ok      (up_ok[gi]),
        .dn_ok      (dn_ok[gi]),
        .dly_on     (dly_on_i),
        .dly_off    (dly_off_i),
        .clk_en     (clk_en_o[gi]),
        .reset_n    (reset_n_o[gi]),
        .state      (st[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_red_pitaya_rst_clken_seq.sv
// Bench for the reset / clock-enable sequencer: one independent and one
// chained instance, directed tables, corner sequences and random stimulus.
module tb_red_pitaya_rst_clken_seq;

  localparam int CH = 4;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en0 = '0, en1 = '0;
  logic [W-1:0]  don0 = '0, doff0 = '0, don1 = '0, doff1 = '0;
  logic [CH-1:0] ce0, rn0, rdy0, ce1, rn1, rdy1;
  logic          busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  red_pitaya_rst_clken_seq #(.CH(CH), .CTR_W(W), .SEQ_MODE(0)) u_ind (
    .clk(clk), .global_rst(rst), .enable_i(en0), .dly_on_i(don0), .dly_off_i(doff0),
    .clk_en_o(ce0), .reset_n_o(rn0), .ready_o(rdy0), .busy_o(busy0)
  );

  red_pitaya_rst_clken_seq #(.CH(CH), .CTR_W(W), .SEQ_MODE(1)) u_seq (
    .clk(clk), .global_rst(rst), .enable_i(en1), .dly_on_i(don1), .dly_off_i(doff1),
    .clk_en_o(ce1), .reset_n_o(rn1), .ready_o(rdy1), .busy_o(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per channel "clock running", "out of reset", direction
  // of travel and remaining delay; outputs lag the model state by one cycle.
  bit            m_run  [2][CH];
  bit            m_live [2][CH];
  bit            m_up   [2][CH];
  int            m_cnt  [2][CH];
  logic [CH-1:0] m_ce   [2];
  logic [CH-1:0] m_rn   [2];
  logic          m_busy [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < CH; k++) begin
        m_run[d][k] = 0; m_live[d][k] = 0; m_up[d][k] = 0; m_cnt[d][k] = 0;
      end
      m_ce[d] = '0; m_rn[d] = '0; m_busy[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [CH-1:0] en, input int don, input int doff);
    bit            w [CH];
    bit            acc, ok;
    logic [CH-1:0] rdy_old;
    rdy_old = m_ce[d] & m_rn[d];
    acc = 1'b1;
    for (int k = 0; k < CH; k++) begin
      acc  = (d == 1) ? (acc & en[k]) : en[k];
      w[k] = acc;
    end
    m_busy[d] = 1'b0;
    for (int k = 0; k < CH; k++) begin
      m_ce[d][k] = m_run[d][k];
      m_rn[d][k] = m_live[d][k];
      if (m_run[d][k] && !m_live[d][k]) m_busy[d] = 1'b1;
    end
    // Ascending order: channel k+1 has not been updated yet when k reads it.
    for (int k = 0; k < CH; k++) begin
      if (!m_run[d][k]) begin
        ok = (d == 0) || (k == 0);
        if (!ok) ok = rdy_old[k-1];
        if (w[k] && ok) begin
          m_run[d][k] = 1; m_live[d][k] = 0; m_up[d][k] = 1; m_cnt[d][k] = don;
        end
      end else if (m_live[d][k]) begin
        ok = (d == 0) || (k == CH - 1);
        if (!ok) ok = !m_run[d][k+1];
        if (!w[k] && ok) begin
          m_live[d][k] = 0; m_up[d][k] = 0; m_cnt[d][k] = doff;
        end
      end else if (m_up[d][k]) begin
        if (!w[k]) begin m_up[d][k] = 0; m_cnt[d][k] = doff; end
        else if (m_cnt[d][k] == 0) m_live[d][k] = 1;
        else m_cnt[d][k]--;
      end else begin
        if (w[k]) begin m_up[d][k] = 1; m_cnt[d][k] = don; end
        else if (m_cnt[d][k] == 0) m_run[d][k] = 0;
        else m_cnt[d][k]--;
      end
    end
  endtask

  typedef struct packed {
    logic          rst;
    logic [CH-1:0] en;
    logic [W-1:0]  don;
    logic [W-1:0]  doff;
    logic [CH-1:0] ce;
    logic [CH-1:0] rn;
    logic [CH-1:0] rdy;
    logic          busy;
  } vec_t;

  vec_t          vt [20];
  logic [CH-1:0] up_seq [4];
  logic [CH-1:0] dn_seq [4];
  logic [CH-1:0] prev, ce_h1, rdy_h1, rdy_h2;
  int            idx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst, en, dly_on, dly_off -> ce, rn, rdy, busy (after that edge)
    vt[0]  = '{1'b1, 4'b0000, 4'd3, 4'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[1]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[2]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[3]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[4]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[5]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[6]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0100, 4'b0100, 1'b0};
    vt[7]  = '{1'b0, 4'b0100, 4'd3, 4'd2, 4'b0100, 4'b0100, 4'b0100, 1'b0};
    vt[8]  = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0100, 4'b0100, 4'b0100, 1'b0};
    vt[9]  = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[10] = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[11] = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0100, 4'b0000, 4'b0000, 1'b1};
    vt[12] = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[13] = '{1'b0, 4'b0000, 4'd3, 4'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[14] = '{1'b0, 4'b0001, 4'd0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[15] = '{1'b0, 4'b0001, 4'd0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vt[16] = '{1'b0, 4'b0001, 4'd0, 4'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0};
    vt[17] = '{1'b0, 4'b0000, 4'd0, 4'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0};
    vt[18] = '{1'b0, 4'b0000, 4'd0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vt[19] = '{1'b0, 4'b0000, 4'd0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    up_seq[0] = 4'b0001; up_seq[1] = 4'b0011; up_seq[2] = 4'b0111; up_seq[3] = 4'b1111;
    dn_seq[0] = 4'b0111; dn_seq[1] = 4'b0011; dn_seq[2] = 4'b0001; dn_seq[3] = 4'b0000;

    // Wake / drain timing on the independent instance, including zero delays.
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; en0 = vt[i].en; don0 = vt[i].don; doff0 = vt[i].doff;
      tick();
      chk($sformatf("tbl%0d", i), 32'({ce0, rn0, rdy0, busy0}),
          32'({vt[i].ce, vt[i].rn, vt[i].rdy, vt[i].busy}));
    end

    // Abort mid-wake; the drain delay changes after it was loaded.
    for (int i = 0; i < 10; i++) begin
      en0   = (i < 3) ? 4'b0010 : 4'b0000;
      don0  = 4'd5;
      doff0 = (i <= 3) ? 4'd2 : 4'd9;
      tick();
      chk($sformatf("abort_ce%0d", i), 32'(ce0[1]), 32'((i >= 1) && (i <= 6)));
      chk($sformatf("abort_rn%0d", i), 32'(rn0[1]), 32'd0);
    end

    // Ordered power-up, then ordered power-down of the chained instance.
    en1 = 4'b1111; don1 = 4'd1; doff1 = 4'd1;
    prev = rdy1; idx = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (rdy1 != prev) begin
        chk($sformatf("seq_up%0d", idx), 32'(rdy1), 32'((idx < 4) ? up_seq[idx] : 4'b1111));
        idx++;
        prev = rdy1;
      end
    end
    chk("seq_up_steps", 32'(idx), 32'd4);
    en1 = 4'b1110;
    prev = ce1; idx = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ce1 != prev) begin
        chk($sformatf("seq_dn%0d", idx), 32'(ce1), 32'((idx < 4) ? dn_seq[idx] : 4'b0000));
        idx++;
        prev = ce1;
      end
    end
    chk("seq_dn_steps", 32'(idx), 32'd4);

    // Reset while channels sit in DRAIN, ON and WAKE.
    en0 = 4'b0011; don0 = 4'd2; doff0 = 4'd2;
    for (int c = 0; c < 6; c++) tick();
    en0 = 4'b0110;
    tick();
    tick();
    chk("pre_rst", 32'({ce0, rn0, busy0}), 32'({4'b0111, 4'b0010, 1'b1}));
    rst = 1'b1;
    tick();
    chk("rst_all0", 32'({ce0, rn0, rdy0, busy0, ce1, rn1, rdy1, busy1}), 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_ce_a", 32'(ce0), 32'd0);
    tick();
    chk("restart_ce_b", 32'({ce0, rn0}), 32'({4'b0110, 4'b0000}));

    // Random enables and delays against the reference model.
    rst = 1'b1; en0 = '0; en1 = '0;
    tick();
    model_reset();
    rst = 1'b0;
    ce_h1 = '0; rdy_h1 = '0; rdy_h2 = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) en0 = en0 ^ (4'b0001 << $urandom_range(0, CH-1));
      if ($urandom_range(0, 5) == 0) en1 = en1 ^ (4'b0001 << $urandom_range(0, CH-1));
      don0 = W'($urandom_range(0, 5)); doff0 = W'($urandom_range(0, 5));
      don1 = W'($urandom_range(0, 4)); doff1 = W'($urandom_range(0, 4));
      @(posedge clk);
      model_step(0, en0, int'(don0), int'(doff0));
      model_step(1, en1, int'(don1), int'(doff1));
      #1;
      chk("rnd_ind", 32'({ce0, rn0, rdy0, busy0}),
          32'({m_ce[0], m_rn[0], m_ce[0] & m_rn[0], m_busy[0]}));
      chk("rnd_seq", 32'({ce1, rn1, rdy1, busy1}),
          32'({m_ce[1], m_rn[1], m_ce[1] & m_rn[1], m_busy[1]}));
      chk("inv_ind", 32'(rn0 & ~ce0), 32'd0);
      chk("inv_seq", 32'(rn1 & ~ce1), 32'd0);
      for (int k = 1; k < CH; k++)
        if (ce1[k] && !ce_h1[k]) chk($sformatf("ord_up%0d", k), 32'(rdy_h2[k-1]), 32'd1);
      for (int k = 0; k < CH - 1; k++)
        if (!rn1[k] && rdy_h1[k]) chk($sformatf("ord_dn%0d", k), 32'(ce_h1[k+1]), 32'd0);
      rdy_h2 = rdy_h1;
      rdy_h1 = rdy1;
      ce_h1  = ce1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
